// File: rtl/spi_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter_if
//
// Bundles the requester-side handshake and the SPI-master-side control bus of
// spi_master_arbiter into one interface.
//
// Parameters
//   DATA_WIDTH : SPI word width in bits
//   N_REQ      : number of requesters
//
// Signals
//   req        : per-requester transfer request (level, held until own done)
//   wdata      : per-requester TX word, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        : one-hot grant
//   done       : one-cycle completion pulse to the granted requester
//   rdata      : word received for the last completed transfer
//   m_start    : start pulse to the SPI master
//   m_data_in  : TX word presented to the SPI master
//   m_busy     : SPI master busy flag
//   m_data_out : RX word returned by the SPI master
//
// Modports
//   master : the arbiter side (drives grants, completion and master controls)
//   slave  : the environment side (requesters plus the SPI master)
// -----------------------------------------------------------------------------
interface spi_master_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]       rdata;
    logic                        m_start;
    logic [DATA_WIDTH-1:0]       m_data_in;
    logic                        m_busy;
    logic [DATA_WIDTH-1:0]       m_data_out;

    modport master (
        input  req, wdata, m_busy, m_data_out,
        output gnt, done, rdata, m_start, m_data_in
    );

    modport slave (
        output req, wdata, m_busy, m_data_out,
        input  gnt, done, rdata, m_start, m_data_in
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares one SPI master between N_REQ requesters. A winner is picked in IDLE
// (only while the SPI master is idle), its TX word is latched, the master is
// started, and when the master finishes the RX word is captured and the
// winner receives a one-cycle done pulse.
//
// Timing, with req sampled at grant edge E0:
//   after E0 : gnt one-hot, m_data_in latched           (state START)
//   after E1 : m_start high for exactly one cycle       (state WAIT_BUSY)
//   then     : wait for m_busy to rise, then to fall; on the falling-busy edge
//              rdata is captured, done[winner] pulses, gnt clears, back to IDLE.
//
// Ports
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : spi_master_arbiter_if.master (req/wdata/gnt/done/rdata and the
//           m_* SPI master controls)
//
// Configuration
//   SPI_ARB_RR_EN : when defined, round-robin arbitration (search starts at a
//                   pointer that moves to winner+1 on every grant); otherwise
//                   fixed priority with the lowest index winning.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_master_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e                state_q,     state_d;
    logic [N_REQ-1:0]      gnt_q,       gnt_d;
    logic [N_REQ-1:0]      done_q,      done_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic                  m_start_q,   m_start_d;
    logic [DATA_WIDTH-1:0] m_data_in_q, m_data_in_d;

    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;

    // Reduce any non-negative index modulo N_REQ to a requester index.
    function automatic logic [IDX_W-1:0] wrap_idx(input int i);
        return IDX_W'(i % N_REQ);
    endfunction

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
`ifdef SPI_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Search upward from the pointer with wrap; the first requester hit wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_valid && bus.req[wrap_idx(int'(ptr_q) + k)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(int'(ptr_q) + k);
            end
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_valid && bus.req[k]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        m_start_d   = 1'b0;
        m_data_in_d = m_data_in_q;
`ifdef SPI_ARB_RR_EN
        ptr_d       = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                // A busy master (e.g. still finishing a transfer aborted by
                // reset) blocks new grants.
                if (win_valid && !bus.m_busy) begin
                    gnt_d       = N_REQ'(1) << win_idx;
                    m_data_in_d = bus.wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef SPI_ARB_RR_EN
                    ptr_d       = wrap_idx(int'(win_idx) + 1);
`endif
                    state_d     = START;
                end
            end

            START: begin
                // Registered, so the pulse appears in the cycle after START.
                m_start_d = 1'b1;
                state_d   = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (bus.m_busy) begin
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                // req is deliberately not looked at here: a requester that
                // drops its request mid-transfer still gets its done pulse.
                if (!bus.m_busy) begin
                    rdata_d = bus.m_data_out;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            m_start_q   <= 1'b0;
            m_data_in_q <= '0;
`ifdef SPI_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            m_start_q   <= m_start_d;
            m_data_in_q <= m_data_in_d;
`ifdef SPI_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.m_start   = m_start_q;
    assign bus.m_data_in = m_data_in_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Self-checking bench for spi_master_arbiter. A small transaction-level model
// predicts gnt/done/rdata/m_start/m_data_in and is compared against the DUT on
// every falling edge; directed scenarios add hand-computed literal checks.
// A simple behavioural SPI master answers m_start with a busy window.
// Builds with or without SPI_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;
    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int BOUND = 60;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_master_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(NR)) bus ();

    spi_master_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus-owned drivers
    logic [NR-1:0]    req_drv    = '0;
    logic [NR*DW-1:0] wdata_drv  = '0;
    logic             ext_busy   = 1'b0;
    logic [DW-1:0]    slave_resp = '0;
    int               busy_len   = 3;

    // Behavioural SPI master
    logic             fm_busy = 1'b0;
    logic [DW-1:0]    fm_data = '0;
    int               fm_cnt  = 0;

    assign bus.req        = req_drv;
    assign bus.wdata      = wdata_drv;
    assign bus.m_busy     = fm_busy | ext_busy;
    assign bus.m_data_out = fm_data;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // SPI master: on seeing m_start, go busy for busy_len cycles, then return
    // slave_resp and drop busy.
    always @(negedge clk) begin
        if (fm_cnt != 0) begin
            fm_cnt = fm_cnt - 1;
            if (fm_cnt == 0) begin
                fm_busy = 1'b0;
                fm_data = slave_resp;
            end
        end else if (bus.m_start) begin
            fm_busy = 1'b1;
            fm_cnt  = busy_len;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: one outstanding transfer, described by its owner, the
    // number of edges since the grant and whether the master has gone busy.
    // Fixed priority is the round-robin search with the pointer pinned at 0.
    // ------------------------------------------------------------------------
    logic [NR-1:0] exp_gnt    = '0;
    logic [NR-1:0] exp_done   = '0;
    logic [DW-1:0] exp_rdata  = '0;
    logic [DW-1:0] exp_mdin   = '0;
    logic          exp_mstart = 1'b0;
    bit            own_v      = 1'b0;
    bit            seen_busy  = 1'b0;
    int            age        = 0;
    int            rr_ptr     = 0;

    function automatic int pick(input logic [NR-1:0] r, input int ptr);
        int w;
        w = -1;
        for (int k = NR - 1; k >= 0; k--) begin
            if (r[(ptr + k) % NR]) w = (ptr + k) % NR;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            own_v      = 1'b0;
            seen_busy  = 1'b0;
            age        = 0;
            rr_ptr     = 0;
            exp_gnt    = '0;
            exp_done   = '0;
            exp_rdata  = '0;
            exp_mdin   = '0;
            exp_mstart = 1'b0;
        end else begin
            exp_done = '0;
            if (own_v) begin
                // The master can only respond from the second edge on.
                if (age >= 1) begin
                    if (seen_busy && !bus.m_busy) begin
                        exp_rdata = bus.m_data_out;
                        exp_done  = exp_gnt;
                        exp_gnt   = '0;
                        own_v     = 1'b0;
                    end else if (bus.m_busy) begin
                        seen_busy = 1'b1;
                    end
                end
                age = age + 1;
            end else if (bus.req != '0 && !bus.m_busy) begin
                w         = pick(bus.req, rr_ptr);
                exp_gnt   = NR'(1) << w;
                exp_mdin  = bus.wdata[w*DW +: DW];
`ifdef SPI_ARB_RR_EN
                rr_ptr    = (w + 1) % NR;
`endif
                own_v     = 1'b1;
                age       = 0;
                seen_busy = 1'b0;
            end
            exp_mstart = own_v && (age == 1);
        end
    end

    // Compare process plus per-requester done counter.
    bit cmp_en = 1'b0;
    int done_cnt [NR] = '{default: 0};

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_gnt",       32'(bus.gnt),       32'(exp_gnt));
            check("cyc_done",      32'(bus.done),      32'(exp_done));
            check("cyc_rdata",     32'(bus.rdata),     32'(exp_rdata));
            check("cyc_m_start",   32'(bus.m_start),   32'(exp_mstart));
            check("cyc_m_data_in", 32'(bus.m_data_in), 32'(exp_mdin));
            for (int i = 0; i < NR; i++) begin
                if (bus.done[i]) done_cnt[i]++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int idx);
        bit seen;
        seen = 1'b0;
        idx  = -1;
        for (int n = 0; n < BOUND && !seen; n++) begin
            tick();
            if (bus.gnt != '0) seen = 1'b1;
        end
        check("gnt_seen", 32'(seen), 32'd1);
        for (int i = 0; i < NR; i++) begin
            if (seen && bus.gnt[i]) idx = i;
        end
    endtask

    task automatic wait_done(input int idx);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < BOUND && !seen; n++) begin
            tick();
            if (idx >= 0 && bus.done[idx]) seen = 1'b1;
        end
        check($sformatf("done_seen_%0d", idx), 32'(seen), 32'd1);
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < BOUND && !seen; n++) begin
            tick();
            if (bus.m_start) seen = 1'b1;
        end
        check("m_start_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        int idx;
        int exp_o;
        int exp_dc;
        int snap;
        int n;

        // Reset state
        tick();
        cmp_en = 1'b1;
        check("rst_gnt",       32'(bus.gnt),       32'h0);
        check("rst_done",      32'(bus.done),      32'h0);
        check("rst_rdata",     32'(bus.rdata),     32'h0);
        check("rst_m_start",   32'(bus.m_start),   32'h0);
        check("rst_m_data_in", 32'(bus.m_data_in), 32'h0);
        reset = 1'b0;
        tick();

        // Contention: all four request and keep requesting for 4 transfers.
        wdata_drv = {8'h44, 8'h33, 8'h22, 8'h11};
        req_drv   = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            slave_resp = 8'hA0 + 8'(t);
`ifdef SPI_ARB_RR_EN
            exp_o = t;
`else
            exp_o = 0;
`endif
            wait_gnt(idx);
            check($sformatf("cont_order_%0d", t), 32'(idx), 32'(exp_o));
            check("cont_m_data_in", 32'(bus.m_data_in), 32'(17 * (exp_o + 1)));
            wait_done(idx);
            check("cont_rdata", 32'(bus.rdata), 32'(8'hA0 + 8'(t)));
            if (t == 3) req_drv = '0;
        end
        tick();
        for (int i = 0; i < NR; i++) begin
`ifdef SPI_ARB_RR_EN
            exp_dc = 1;
`else
            exp_dc = (i == 0) ? 4 : 0;
`endif
            check($sformatf("cont_done_cnt_%0d", i), 32'(done_cnt[i]), 32'(exp_dc));
        end

        // Single request, with wdata changed after the grant.
        wdata_drv = '0;
        wdata_drv[0 +: DW] = 8'hAB;
        slave_resp = 8'h55;
        req_drv = 4'b0001;
        tick();
        check("single_gnt",          32'(bus.gnt),       32'h1);
        check("single_m_data_in",    32'(bus.m_data_in), 32'hAB);
        check("single_m_start_pre",  32'(bus.m_start),   32'h0);
        wdata_drv[0 +: DW] = 8'hCD;
        tick();
        check("single_m_start",      32'(bus.m_start),   32'h1);
        tick();
        check("single_m_start_post", 32'(bus.m_start),   32'h0);
        check("single_hold_data",    32'(bus.m_data_in), 32'hAB);
        check("single_hold_gnt",     32'(bus.gnt),       32'h1);
        wait_done(0);
        check("single_rdata",        32'(bus.rdata),     32'h55);
        check("single_done_gnt",     32'(bus.gnt),       32'h0);
        check("single_done_data",    32'(bus.m_data_in), 32'hAB);
        req_drv = '0;
        tick();
        check("single_done_width",   32'(bus.done),      32'h0);
        check("single_rdata_hold",   32'(bus.rdata),     32'h55);

        // Busy hold-off in IDLE.
        ext_busy = 1'b1;
        wdata_drv[1*DW +: DW] = 8'h5A;
        slave_resp = 8'h66;
        req_drv = 4'b0010;
        repeat (4) begin
            tick();
            check("holdoff_gnt", 32'(bus.gnt), 32'h0);
        end
        ext_busy = 1'b0;
        tick();
        check("holdoff_release_gnt",  32'(bus.gnt),       32'h2);
        check("holdoff_release_data", 32'(bus.m_data_in), 32'h5A);
        wait_done(1);
        check("holdoff_rdata", 32'(bus.rdata), 32'h66);
        req_drv = '0;

        // Request dropped while waiting for the master to finish.
        wdata_drv[2*DW +: DW] = 8'h77;
        slave_resp = 8'h3C;
        req_drv = 4'b0100;
        wait_start();
        tick();
        req_drv = '0;
        wait_done(2);
        check("drop_rdata", 32'(bus.rdata), 32'h3C);
        repeat (4) begin
            tick();
            check("drop_no_regrant", 32'(bus.gnt), 32'h0);
        end

        // Reset while waiting for the master; master stays busy afterwards.
        busy_len = 8;
        wdata_drv[0 +: DW] = 8'h12;
        slave_resp = 8'h99;
        req_drv = 4'b0001;
        wait_start();
        tick();
        tick();
        snap = done_cnt[0];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_gnt",       32'(bus.gnt),       32'h0);
        check("rstmid_done",      32'(bus.done),      32'h0);
        check("rstmid_rdata",     32'(bus.rdata),     32'h0);
        check("rstmid_m_data_in", 32'(bus.m_data_in), 32'h0);
        n = 0;
        while (bus.m_busy && n < BOUND) begin
            check("rstmid_wait_gnt", 32'(bus.gnt), 32'h0);
            tick();
            n++;
        end
        check("rstmid_busy_released", 32'(n < BOUND), 32'h1);
        busy_len = 3;
        tick();
        check("rstmid_regrant",  32'(bus.gnt), 32'h1);
        check("rstmid_no_done",  32'(done_cnt[0]), 32'(snap));
        wait_done(0);
        check("rstmid_rdata_after", 32'(bus.rdata), 32'h99);
        req_drv = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
